// File: rtl/mips_mem_pkg.sv
// Purpose : shared widths and entry type for the data-memory store buffer.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: ADDR_W/DATA_W match the single-port data memory; SB_DEPTH and
//           SB_PTR_W are the default buffer depth and its pointer width.
package mips_mem_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  // One buffered store: word address plus the data to write there.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Purpose : CPU store/load handshake plus data-memory port of the store buffer.
// Latency : n/a (wiring only).
// Backpressure : st_ready / ld_ready are driven by the buffer (slave side).
// Ports   : store  st_valid/st_addr/st_data -> st_ready
//           load   ld_valid/ld_addr -> ld_ready/ld_data/ld_fwd
//           memory MemWrite/Memread/address/writeData -> readData; status empty
interface mem_store_buffer_if;
  import mips_mem_pkg::*;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;

  logic              empty;

  logic              MemWrite;
  logic              Memread;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;

  // The store buffer itself.
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, readData,
    output st_ready, ld_ready, ld_data, ld_fwd, empty,
           MemWrite, Memread, address, writeData
  );

  // CPU MEM stage plus data memory, seen from outside the buffer.
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, readData,
    input  st_ready, ld_ready, ld_data, ld_fwd, empty,
           MemWrite, Memread, address, writeData
  );

endinterface

// File: rtl/mem_store_buffer_fwd_match.sv
// Purpose : finds the youngest buffered store whose address equals ld_addr.
// Latency : combinational.
// Backpressure : none.
// Ports   : entries/head/count describe the live FIFO window; hit/data report
//           whether any live entry matches and the youngest match's data.
module sb_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = SB_PTR_W
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [PW:0]       count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overwrites an earlier one, so the
  // surviving value is the youngest. Pointer arithmetic wraps modulo DEPTH.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Purpose : store buffer in front of the word-addressed data memory; queues
//           stores, drains one per free memory cycle, forwards to loads.
// Latency : loads combinational when ld_ready; a store accepted at edge N can
//           be written to memory at edge N+1.
// Backpressure : st_ready low when full; ld_ready low on a miss while full.
// Ports   : clk, reset (sync, active high); bus = mem_store_buffer_if.slave.
// Option  : STORE_COALESCE_EN merges a store into the youngest entry when the
//           addresses match (not into a head that is draining this cycle).
module mem_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  mem_store_buffer_if.slave bus
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  sb_entry_t         entries [DEPTH];
  sb_entry_t         head_e;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic              full;
  logic              match_hit;
  logic [DATA_W-1:0] match_data;
  logic              hit;
  logic              drain;
  logic              coal;
  logic              st_acc;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ld_addr (bus.ld_addr),
    .hit     (match_hit),
    .data    (match_data)
  );

  assign head_e = entries[head];
  assign full   = (count == FULL_CNT);
  assign hit    = bus.ld_valid & match_hit;

  // The memory port goes to the drain unless a missing load needs it; a full
  // buffer always drains so a stalled load cannot deadlock the pipeline.
  assign drain  = ~reset & (count != '0) & (~bus.ld_valid | hit | full);

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] tail_m1;
  assign tail_m1 = tail - 1'b1;
  // With one entry the youngest is also the head; merging into it while it
  // drains would lose the new data, so that case allocates instead.
  assign coal = ~reset & bus.st_valid & (count != '0)
              & (entries[tail_m1].addr == bus.st_addr)
              & ~(drain & (count == (PW+1)'(1)));
`else
  assign coal = 1'b0;
`endif

  // Space is judged on the registered count only; a concurrent drain does not
  // open a slot in the same cycle.
  assign bus.st_ready  = ~reset & (~full | coal);
  assign st_acc        = bus.st_valid & bus.st_ready & ~coal;

  assign bus.MemWrite  = drain;
  assign bus.Memread   = ~reset & bus.ld_valid & ~hit & ~drain;
  assign bus.address   = drain ? head_e.addr : (bus.Memread ? bus.ld_addr : '0);
  assign bus.writeData = drain ? head_e.data : '0;

  assign bus.ld_ready  = ~reset & bus.ld_valid & (hit | ~drain);
  assign bus.ld_fwd    = ~reset & hit;
  assign bus.ld_data   = hit ? match_data : (bus.Memread ? bus.readData : '0);
  assign bus.empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (st_acc) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      count <= count + (PW+1)'(st_acc) - (PW+1)'(drain);
    end
  end

  // Payload needs no reset: only entries inside the head..tail window are read.
  always_ff @(posedge clk) begin
    if (st_acc) entries[tail] <= '{addr: bus.st_addr, data: bus.st_data};
`ifdef STORE_COALESCE_EN
    if (coal)   entries[tail_m1].data <= bus.st_data;
`endif
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_store_buffer_if bus();

  mem_store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write at the edge on MemWrite.
  // Locations never written return fixed preset contents.
  bit [DATA_W-1:0] dmem    [4096];
  bit              wr_seen [4096];

  function automatic logic [DATA_W-1:0] preset(input logic [ADDR_W-1:0] a);
    case (a)
      12'h002: return 32'h0000_0BAD;
      12'h003: return 32'h0000_0007;
      12'h100: return 32'h0000_0055;
      12'h200: return 32'h0000_0077;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return wr_seen[a] ? dmem[a] : preset(a);
  endfunction

  always_comb begin
    bus.readData = wr_seen[bus.address] ? dmem[bus.address] : preset(bus.address);
  end

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      dmem[bus.address]    <= bus.writeData;
      wr_seen[bus.address] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
  endtask

  task automatic st(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic ld(input logic [ADDR_W-1:0] a);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp9;

    // Reset with requests pending: nothing may be accepted or issued.
    reset = 1'b1;
    idle();
    st(12'h001, 32'h1);
    ld(12'h100);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_st_ready", 32'(bus.st_ready), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_memread",  32'(bus.Memread),  32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    cyc();
    reset = 1'b0;
    idle();

    // 1: single store drains the next cycle.
    st(12'h005, 32'h13);
    @(negedge clk);
    chk("t1_st_ready", 32'(bus.st_ready), 32'd1);
    chk("t1_no_write", 32'(bus.MemWrite), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t1_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("t1_address",  32'(bus.address),  32'h5);
    chk("t1_wdata",    32'(bus.writeData), 32'h13);
    chk("t1_not_empty", 32'(bus.empty),   32'd0);
    cyc();
    @(negedge clk);
    chk("t1_empty",    32'(bus.empty),    32'd1);
    chk("t1_mem5",     mem_rd(12'h005),   32'h13);
    cyc();

    // 2: two stores to 7 held in the buffer by a missing load, then a hit.
    st(12'h007, 32'hA);
    ld(12'h100);
    @(negedge clk);
    chk("t2_miss_ready", 32'(bus.ld_ready), 32'd1);
    chk("t2_miss_data",  bus.ld_data,       32'h55);
    chk("t2_memread",    32'(bus.Memread),  32'd1);
    cyc();
    st(12'h007, 32'hB);
    @(negedge clk);
    chk("t2_hold_nowrite", 32'(bus.MemWrite), 32'd0);
    chk("t2_hold_data",    bus.ld_data,       32'h55);
    cyc();
    bus.st_valid = 1'b0;
    ld(12'h007);
    @(negedge clk);
    chk("t2_fwd_data",  bus.ld_data,        32'hB);
    chk("t2_fwd_flag",  32'(bus.ld_fwd),    32'd1);
    chk("t2_fwd_ready", 32'(bus.ld_ready),  32'd1);
    chk("t2_drain",     32'(bus.MemWrite),  32'd1);
    chk("t2_drain_addr", 32'(bus.address),  32'h7);
    chk("t2_drain_data", bus.writeData,     32'hA);
    cyc();
    idle();
    @(negedge clk);
    chk("t2_drain2_data", bus.writeData,    32'hB);
    cyc();
    @(negedge clk);
    chk("t2_empty", 32'(bus.empty), 32'd1);
    chk("t2_mem7",  mem_rd(12'h007), 32'hB);
    cyc();

    // 3: same-cycle store is not forwarded; then a plain miss.
    st(12'h002, 32'h22);
    ld(12'h002);
    @(negedge clk);
    chk("t3_same_fwd",  32'(bus.ld_fwd),   32'd0);
    chk("t3_same_data", bus.ld_data,       32'h0BAD);
    chk("t3_same_rdy",  32'(bus.ld_ready), 32'd1);
    cyc();
    bus.st_valid = 1'b0;
    ld(12'h003);
    @(negedge clk);
    chk("t3_memread", 32'(bus.Memread),  32'd1);
    chk("t3_address", 32'(bus.address),  32'h3);
    chk("t3_ld_data", bus.ld_data,       32'h7);
    chk("t3_ld_fwd",  32'(bus.ld_fwd),   32'd0);
    chk("t3_nodrain", 32'(bus.MemWrite), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t3_drain_addr", 32'(bus.address), 32'h2);
    cyc();
    @(negedge clk);
    chk("t3_empty", 32'(bus.empty), 32'd1);
    cyc();

    // 4: fill to DEPTH under a missing load, then forced drain.
    ld(12'h200);
    for (int i = 0; i < 4; i++) begin
      st(12'h010 + 12'(i), 32'h100 + 32'(i));
      @(negedge clk);
      chk("t4_fill_ld_ready", 32'(bus.ld_ready), 32'd1);
      cyc();
    end
    st(12'h014, 32'h1FF);
    @(negedge clk);
    chk("t4_full_st_ready", 32'(bus.st_ready), 32'd0);
    chk("t4_forced_drain",  32'(bus.MemWrite), 32'd1);
    chk("t4_drain_addr",    32'(bus.address),  32'h10);
    chk("t4_ld_stall",      32'(bus.ld_ready), 32'd0);
    chk("t4_no_read",       32'(bus.Memread),  32'd0);
    cyc();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("t4_ld_ready3", 32'(bus.ld_ready), 32'd1);
    chk("t4_ld_data3",  bus.ld_data,       32'h77);
    chk("t4_memread3",  32'(bus.Memread),  32'd1);
    chk("t4_nowrite3",  32'(bus.MemWrite), 32'd0);
    cyc();

    // 5: reset with three entries (0x11..0x13) still buffered.
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_nowrite", 32'(bus.MemWrite), 32'd0);
    chk("t5_rst_ldrdy",   32'(bus.ld_ready), 32'd0);
    cyc();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_post_nowrite", 32'(bus.MemWrite), 32'd0);
      chk("t5_post_empty",   32'(bus.empty),    32'd1);
      cyc();
    end
    chk("t5_mem10", mem_rd(12'h010), 32'h100);
    chk("t5_mem11", mem_rd(12'h011), 32'h0);
    chk("t5_mem12", mem_rd(12'h012), 32'h0);
    chk("t5_mem13", mem_rd(12'h013), 32'h0);

    // 6: second store to the youngest address while full.
    ld(12'h200);
    st(12'h020, 32'h1); cyc();
    st(12'h021, 32'h2); cyc();
    st(12'h022, 32'h3); cyc();
    st(12'h009, 32'h91); cyc();
    st(12'h009, 32'h92);
    @(negedge clk);
`ifdef STORE_COALESCE_EN
    chk("t6_coal_st_ready", 32'(bus.st_ready), 32'd1);
    exp9 = 32'h92;
`else
    chk("t6_full_st_ready", 32'(bus.st_ready), 32'd0);
    exp9 = 32'h91;
`endif
    chk("t6_forced_drain", 32'(bus.MemWrite), 32'd1);
    chk("t6_drain_addr",   32'(bus.address),  32'h20);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_drain_a21", 32'(bus.address), 32'h21);
    cyc();
    @(negedge clk);
    chk("t6_drain_a22", 32'(bus.address), 32'h22);
    cyc();
    @(negedge clk);
    chk("t6_drain_a9", 32'(bus.address),  32'h9);
    chk("t6_drain_d9", bus.writeData,     exp9);
    cyc();
    @(negedge clk);
    chk("t6_empty", 32'(bus.empty),  32'd1);
    chk("t6_mem9",  mem_rd(12'h009), exp9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
